// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter sharing one bank of JK latch cells between two requesters
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   reqN_valid/cmd/idx    command from requester N (cmd 00 hold, 01 reset, 10 set, 11 toggle)
//   reqN_ready            command from requester N accepted this cycle
//   J, K, En              per-cell latch drive, active only during the enable pulse
//   q_state               shadow copy of the bank contents
//   done/done_id/done_err completion pulse, owning requester, out-of-range flag
module jk_bank_arbiter #(
  parameter int WIDTH     = 8,
  parameter int IDX_W     = 3,
  parameter int EN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [1:0]       req0_cmd,
  input  logic [IDX_W-1:0] req0_idx,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_cmd,
  input  logic [IDX_W-1:0] req1_idx,
  output logic             req1_ready,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] En,
  output logic [WIDTH-1:0] q_state,
  output logic             done,
  output logic             done_id,
  output logic             done_err
);
  localparam int CW = $clog2(EN_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, PULSE, RECOVER} state_t;
  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             id_q, id_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_state_q, q_state_d;
  logic             grant0, grant1, in_range, last, pulse;
  logic [WIDTH-1:0] sel;
  always_comb begin
    // Pointer only breaks ties; a lone requester always wins.
    grant0    = state_q == IDLE && req0_valid && (!req1_valid || !ptr_q);
    grant1    = state_q == IDLE && req1_valid && (!req0_valid || ptr_q);
    in_range  = {1'b0, idx_q} < (IDX_W+1)'(WIDTH);
    // Out-of-range commands spend exactly one pulse cycle driving nothing.
    last      = !in_range || cnt_q == CW'(EN_CYCLES - 1);
    sel       = in_range ? WIDTH'(1) << idx_q : '0;
    pulse     = state_q == PULSE;
    state_d   = state_q;
    ptr_d     = ptr_q;
    cmd_d     = cmd_q;
    idx_d     = idx_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    q_state_d = q_state_q;
    case (state_q)
      IDLE: if (grant0 || grant1) begin
        state_d = PULSE;
        cmd_d   = grant1 ? req1_cmd : req0_cmd;
        idx_d   = grant1 ? req1_idx : req0_idx;
        id_d    = grant1;
        cnt_d   = '0;
        ptr_d   = (req0_valid && req1_valid) ? !ptr_q : ptr_q;
      end
      PULSE: begin
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d   = RECOVER;
          // Shadow updated once per command, so a toggle flips exactly once.
          q_state_d = cmd_q == 2'b01 ? q_state_q & ~sel :
                      cmd_q == 2'b10 ? q_state_q | sel  :
                      cmd_q == 2'b11 ? q_state_q ^ sel  : q_state_q;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      cmd_q     <= '0;
      idx_q     <= '0;
      id_q      <= 1'b0;
      cnt_q     <= '0;
      q_state_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cmd_q     <= cmd_d;
      idx_q     <= idx_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      q_state_q <= q_state_d;
    end
  end
  assign req0_ready = grant0 && !reset;
  assign req1_ready = grant1 && !reset;
  assign En         = pulse ? sel : '0;
  assign J          = pulse && cmd_q[1] ? sel : '0;
  assign K          = pulse && cmd_q[0] ? sel : '0;
  assign q_state    = q_state_q;
  assign done       = state_q == RECOVER;
  assign done_id    = done && id_q;
  assign done_err   = done && !in_range;
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb_jk_bank_arbiter: directed self-checking bench for jk_bank_arbiter (WIDTH=6, EN_CYCLES=2)
module tb_jk_bank_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [1:0] req0_cmd, req1_cmd;
  logic [2:0] req0_idx, req1_idx;
  logic [5:0] J, K, En, q_state;
  logic       done, done_id, done_err;
  int         total = 0;
  int         bad = 0;
  jk_bank_arbiter #(.WIDTH(6), .IDX_W(3), .EN_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_idx(req0_idx), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_idx(req1_idx), .req1_ready(req1_ready),
    .J(J), .K(K), .En(En), .q_state(q_state),
    .done(done), .done_id(done_id), .done_err(done_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic settle;
    #2;
  endtask
  task automatic drv(input logic vld, input logic [1:0] cmd, input logic [2:0] idx, input logic w);
    if (w) begin req1_valid = vld; req1_cmd = cmd; req1_idx = idx; end
    else begin req0_valid = vld; req0_cmd = cmd; req0_idx = idx; end
  endtask
  task automatic chk_drive(input string tag, input logic [5:0] en, input logic [5:0] j, input logic [5:0] k);
    chk({tag, "_en"}, 32'(En), 32'(en));
    chk({tag, "_j"}, 32'(J), 32'(j));
    chk({tag, "_k"}, 32'(K), 32'(k));
  endtask
  task automatic chk_done(input string tag, input logic d, input logic id, input logic err);
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_id"}, 32'(done_id), 32'(id));
    chk({tag, "_err"}, 32'(done_err), 32'(err));
  endtask
  initial begin
    reset = 1'b1;
    drv(1'b0, 2'b00, 3'd0, 1'b0);
    drv(1'b0, 2'b00, 3'd0, 1'b1);
    tick; tick;
    settle;
    chk_drive("rst", 6'h00, 6'h00, 6'h00);
    chk("rst_q", 32'(q_state), 32'h0);
    chk("rst_rdy", 32'({req0_ready, req1_ready}), 32'h0);
    chk_done("rst", 1'b0, 1'b0, 1'b0);
    // req0 set idx 3
    tick; reset = 1'b0;
    drv(1'b1, 2'b10, 3'd3, 1'b0);
    settle;
    chk("set_rdy", 32'({req0_ready, req1_ready}), 32'h2);
    tick; drv(1'b0, 2'b10, 3'd3, 1'b0); settle;
    chk("set_rdy_drop", 32'({req0_ready, req1_ready}), 32'h0);
    chk_drive("set_p0", 6'h08, 6'h08, 6'h00);
    chk("set_q_p0", 32'(q_state), 32'h0);
    tick; settle;
    chk_drive("set_p1", 6'h08, 6'h08, 6'h00);
    chk("set_q_p1", 32'(q_state), 32'h0);
    tick; settle;
    chk_drive("set_rec", 6'h00, 6'h00, 6'h00);
    chk("set_q", 32'(q_state), 32'h08);
    chk_done("set_rec", 1'b1, 1'b0, 1'b0);
    // req1 toggle idx 3
    tick; drv(1'b1, 2'b11, 3'd3, 1'b1); settle;
    chk_done("idle", 1'b0, 1'b0, 1'b0);
    chk("tg3_rdy", 32'({req0_ready, req1_ready}), 32'h1);
    tick; drv(1'b0, 2'b00, 3'd0, 1'b1); settle;
    chk_drive("tg3_p0", 6'h08, 6'h08, 6'h08);
    tick; tick; settle;
    chk("tg3_q", 32'(q_state), 32'h00);
    chk_done("tg3_rec", 1'b1, 1'b1, 1'b0);
    // req1 toggle idx 0
    tick; drv(1'b1, 2'b11, 3'd0, 1'b1); settle;
    chk("tg0_rdy", 32'({req0_ready, req1_ready}), 32'h1);
    tick; drv(1'b0, 2'b00, 3'd0, 1'b1); settle;
    chk_drive("tg0_p0", 6'h01, 6'h01, 6'h01);
    tick; settle;
    chk_drive("tg0_p1", 6'h01, 6'h01, 6'h01);
    tick; settle;
    chk("tg0_q", 32'(q_state), 32'h01);
    chk_done("tg0_rec", 1'b1, 1'b1, 1'b0);
    tick; settle;
    chk("tg0_q_once", 32'(q_state), 32'h01);
    // both requesters held valid: grants 0,1,0,1 spaced 4 cycles apart
    drv(1'b1, 2'b10, 3'd1, 1'b0);
    drv(1'b1, 2'b10, 3'd2, 1'b1);
    settle;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("rr_rdy0_c%0d", i), 32'(req0_ready), 32'(i % 8 == 0));
      chk($sformatf("rr_rdy1_c%0d", i), 32'(req1_ready), 32'(i % 8 == 4));
      if (i == 15) begin
        drv(1'b0, 2'b00, 3'd0, 1'b0);
        drv(1'b0, 2'b00, 3'd0, 1'b1);
      end
      tick; settle;
    end
    chk("rr_q", 32'(q_state), 32'h07);
    // out-of-range idx 7 with WIDTH=6
    drv(1'b1, 2'b10, 3'd7, 1'b0); settle;
    chk("oor_rdy", 32'({req0_ready, req1_ready}), 32'h2);
    tick; drv(1'b0, 2'b00, 3'd0, 1'b0); settle;
    chk_drive("oor_p", 6'h00, 6'h00, 6'h00);
    chk_done("oor_p", 1'b0, 1'b0, 1'b0);
    tick; settle;
    chk_done("oor_rec", 1'b1, 1'b0, 1'b1);
    chk("oor_q", 32'(q_state), 32'h07);
    // reset during pulse of set idx 5
    tick; drv(1'b1, 2'b10, 3'd5, 1'b1); settle;
    chk("mid_rdy", 32'({req0_ready, req1_ready}), 32'h1);
    tick; drv(1'b0, 2'b00, 3'd0, 1'b1); settle;
    chk_drive("mid_p0", 6'h20, 6'h20, 6'h00);
    reset = 1'b1;
    tick; reset = 1'b0; settle;
    chk_drive("mid_rst", 6'h00, 6'h00, 6'h00);
    chk("mid_q", 32'(q_state), 32'h0);
    chk_done("mid_rst", 1'b0, 1'b0, 1'b0);
    tick; settle;
    chk_done("mid_rst2", 1'b0, 1'b0, 1'b0);
    tick; settle;
    chk_done("mid_rst3", 1'b0, 1'b0, 1'b0);
    // hold on idx 2 granted normally after reset
    drv(1'b1, 2'b00, 3'd2, 1'b0); settle;
    chk("hold_rdy", 32'({req0_ready, req1_ready}), 32'h2);
    tick; drv(1'b0, 2'b00, 3'd0, 1'b0); settle;
    chk_drive("hold_p0", 6'h04, 6'h00, 6'h00);
    tick; settle;
    chk_drive("hold_p1", 6'h04, 6'h00, 6'h00);
    tick; settle;
    chk_done("hold_rec", 1'b1, 1'b0, 1'b0);
    chk("hold_q", 32'(q_state), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
